// File: rtl/seq_pass_detector.sv
// seq_pass_detector: parametrised Moore serial-pattern detector.
// A KMP automaton over the bit-serial input x (qualified by en) raises z while
// the state register sits in MATCH. A saturating, clearable counter tallies
// every accepted edge that lands in MATCH.
//
// State index k (0..PAT_W) means the last k accepted bits equal the first k
// pattern bits; k == PAT_W is MATCH. The next-state table is derived from
// PATTERN while the design elaborates, so retargeting the detector only
// needs new parameter values.
module seq_pass_detector #(
  parameter int                 PAT_W   = 3,
  parameter logic [PAT_W-1:0]   PATTERN = 3'b101,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             x,
  input  logic             clr_cnt,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  // State register width: enough to hold indices 0..PAT_W.
  localparam int SW = $clog2(PAT_W + 1);

  // The state index is numeric rather than a named enum because the number
  // of states follows PAT_W.
  typedef logic [SW-1:0] state_t;

  localparam state_t S0_ST    = '0;
  localparam state_t MATCH_ST = SW'(PAT_W);

  // Reject pattern lengths the detector is not built for.
  if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
    $error("seq_pass_detector: PAT_W=%0d is outside the legal range 2..16", PAT_W);
  end

  // ---------------------------------------------------------------------------
  // Elaboration-time helpers
  // ---------------------------------------------------------------------------

  // Pattern bit in arrival order: index 0 is the first bit received, which
  // lives in the MSB of PATTERN.
  function automatic logic pat_bit(input int i);
    return 1'(16'(PATTERN) >> (PAT_W - 1 - i));
  endfunction

  // Next state from state k when bit b is accepted.
  // The accepted history implied by state k is the first k pattern bits
  // (the whole pattern for MATCH). Appending b and taking the longest pattern
  // prefix that is also a suffix of that history gives the KMP transition.
  // This covers both the forward step (b matches bit k) and every fallback,
  // including MATCH->MATCH for self-overlapping patterns such as 11.
  // Without overlap, a match forgets its history and restarts from S0.
  function automatic int next_of(input int k, input logic b);
    logic [16:0] seq;
    int          len;
    int          best;
    logic        ok;

    if (k == PAT_W && !OVERLAP) begin
      return (b == pat_bit(0)) ? 1 : 0;
    end

    // seq[i] holds the i-th bit of the history, oldest first.
    seq = '0;
    for (int i = 0; i < k; i++) begin
      seq = seq | (17'(pat_bit(i)) << i);
    end
    seq = seq | (17'(b) << k);
    len = k + 1;

    best = 0;
    for (int j = 1; j <= PAT_W; j++) begin
      if (j <= len) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++) begin
          if (1'(seq >> (len - j + i)) != pat_bit(i)) begin
            ok = 1'b0;
          end
        end
        if (ok) begin
          best = j;
        end
      end
    end
    return best;
  endfunction

  // ---------------------------------------------------------------------------
  // Transition table, one entry per state and input bit value
  // ---------------------------------------------------------------------------
  state_t nxt_on0 [PAT_W+1];
  state_t nxt_on1 [PAT_W+1];

  for (genvar gi = 0; gi <= PAT_W; gi++) begin : g_state
    localparam state_t N0 = SW'(next_of(gi, 1'b0));
    localparam state_t N1 = SW'(next_of(gi, 1'b1));
    assign nxt_on0[gi] = N0;
    assign nxt_on1[gi] = N1;
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic             z_q, z_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;

  // Advance the automaton only on qualified bits; otherwise hold.
  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = x ? nxt_on1[state_q] : nxt_on0[state_q];
    end
  end

  // z is the registered decode of the next state, so it reflects the state
  // register after each edge with no combinational path from x or en.
  always_comb begin
    z_d = (state_d == MATCH_ST);
  end

  // Count accepted edges that land in MATCH; clear wins, and the count
  // sticks at all-ones instead of wrapping.
  always_comb begin
    hit   = en && (state_d == MATCH_ST);
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, output and counter registers; reset overrides en and clr_cnt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S0_ST;
      z_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
    end
  end

  assign z         = z_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_pass_detector.sv
// Directed testbench for seq_pass_detector. Several parameterisations share
// one stimulus stream; each check looks at the instance it concerns.
module tb_seq_pass_detector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic x = 1'b0;
  logic clr_cnt = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Default: 101, overlap, 8-bit counter.
  logic       z_def;
  logic [7:0] cnt_def;
  seq_pass_detector u_def (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .clr_cnt(clr_cnt),
    .z(z_def), .match_cnt(cnt_def)
  );

  // 101 without overlap.
  logic       z_novl;
  logic [7:0] cnt_novl;
  seq_pass_detector #(.OVERLAP(1'b0)) u_novl (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .clr_cnt(clr_cnt),
    .z(z_novl), .match_cnt(cnt_novl)
  );

  // 4-bit pattern 1101.
  logic       z_p4;
  logic [7:0] cnt_p4;
  seq_pass_detector #(.PAT_W(4), .PATTERN(4'b1101)) u_p4 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .clr_cnt(clr_cnt),
    .z(z_p4), .match_cnt(cnt_p4)
  );

  // 101 with a 2-bit saturating counter.
  logic       z_c2;
  logic [1:0] cnt_c2;
  seq_pass_detector #(.CNT_W(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .clr_cnt(clr_cnt),
    .z(z_c2), .match_cnt(cnt_c2)
  );

  // Self-overlapping pattern 11: MATCH->MATCH is reachable.
  logic       z_11;
  logic [7:0] cnt_11;
  seq_pass_detector #(.PAT_W(2), .PATTERN(2'b11)) u_11 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .clr_cnt(clr_cnt),
    .z(z_11), .match_cnt(cnt_11)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs away from the edge, then settle past the edge.
  task automatic step(input logic r, input logic e, input logic xv, input logic c);
    @(negedge clk);
    rst_n   = r;
    en      = e;
    x       = xv;
    clr_cnt = c;
    @(posedge clk);
    #1;
    $display("t=%0t rst_n=%0b en=%0b x=%0b clr=%0b | def z=%0b cnt=%0d novl z=%0b cnt=%0d p4 z=%0b c2 z=%0b cnt=%0d p11 z=%0b cnt=%0d",
             $time, r, e, xv, c, z_def, cnt_def, z_novl, cnt_novl, z_p4, z_c2, cnt_c2, z_11, cnt_11);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state.
    do_reset();
    chk("reset_z_def", int'(z_def), 0);
    chk("reset_cnt_def", int'(cnt_def), 0);
    chk("reset_state_def", int'(u_def.state_q), 0);

    // Test 1 and 2: 1,0,1,0,1 on default (overlap) and non-overlap instances.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t1_b1_z", int'(z_def), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1_b2_z", int'(z_def), 0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t1_b3_z", int'(z_def), 1);
    chk("t2_b3_z", int'(z_novl), 1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1_b4_z", int'(z_def), 0);
    chk("t1_b4_state", int'(u_def.state_q), 2);
    chk("t2_b4_state", int'(u_novl.state_q), 0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t1_b5_z", int'(z_def), 1);
    chk("t1_b5_cnt", int'(cnt_def), 2);
    chk("t2_b5_z", int'(z_novl), 0);
    chk("t2_b5_cnt", int'(cnt_novl), 1);

    // Test 3: 1101 with x=1,1,1,0,1 -> S1,S2,S2,S3,MATCH.
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t3_s1", int'(u_p4.state_q), 1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t3_s2", int'(u_p4.state_q), 2);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t3_s2_again", int'(u_p4.state_q), 2);
    chk("t3_z_early", int'(z_p4), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t3_s3", int'(u_p4.state_q), 3);
    chk("t3_z_s3", int'(z_p4), 0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t3_match", int'(u_p4.state_q), 4);
    chk("t3_z", int'(z_p4), 1);
    chk("t3_cnt", int'(cnt_p4), 1);

    // Test 4: en gating.
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4_hold_state", int'(u_def.state_q), 2);
    chk("t4_hold_z", int'(z_def), 0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t4_z", int'(z_def), 1);
    chk("t4_cnt", int'(cnt_def), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4_z_held", int'(z_def), 1);
    chk("t4_cnt_held", int'(cnt_def), 1);

    // Test 5: reset mid-sequence, with en=1 and x=1 that would complete a match.
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t5_rst_state", int'(u_def.state_q), 0);
    chk("t5_rst_z", int'(z_def), 0);
    chk("t5_rst_cnt", int'(cnt_def), 0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t5_s1", int'(u_def.state_q), 1);
    chk("t5_z0", int'(z_def), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t5_z1", int'(z_def), 1);

    // Test 6: 2-bit counter saturates, clear beats a simultaneous match.
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      if (i == 3) chk("t6_cnt_3rd", int'(cnt_c2), 3);
    end
    chk("t6_cnt_sat", int'(cnt_c2), 3);
    chk("t6_cnt_def5", int'(cnt_def), 5);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t6_clr_cnt", int'(cnt_c2), 0);
    chk("t6_clr_z", int'(z_c2), 1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t6_after_clr", int'(cnt_c2), 1);

    // Pattern 11: MATCH->MATCH counts every edge.
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("p11_b1_z", int'(z_11), 0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("p11_b2_z", int'(z_11), 1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("p11_b3_z", int'(z_11), 1);
    chk("p11_b3_cnt", int'(cnt_11), 2);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("p11_b4_z", int'(z_11), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
